wb_rr_interconnect: RTL and testbench
=====================================

WB_RR_INTERCONNECT -- requirements
Module: wb_rr_interconnect

Interface
REQ-001 Parameter NM, 3: number of Wishbone masters (1..8).
REQ-002 Parameter NS, 4: number of Wishbone slaves (1..8).
REQ-003 Parameter AW, 32: address width; DW, 32: data width; SW = DW/8: select width.
REQ-004 Parameter SLV_BASE, NS*AW bits, default {0x1000_1000, 0x1000_0000, 0x0C00_0000, 0x0200_0000}: slave base addresses, slave 0 in the LSBs.
REQ-005 Parameter SLV_MASK, NS*AW bits, default {0xFFFF_F000, 0xFFFF_F000, 0xFF00_0000, 0xFF00_0000}: slave address masks.
REQ-006 Parameter TIMEOUT, 255: maximum number of cycles a slave may stall before an error is returned (1..65535).
REQ-007 clk  in  1  single clock; all logic is on its rising edge.
REQ-008 rst  in  1  synchronous, active-low reset.
REQ-009 m_cyc_i / m_stb_i / m_we_i  in  NM each  per-master Wishbone cycle, strobe and write-enable.
REQ-010 m_addr_i  in  NM*AW; m_wdata_i  in  NM*DW; m_sel_i  in  NM*SW: per-master request fields.
REQ-011 m_rdata_o  out  NM*DW; m_ack_o  out  NM; m_err_o  out  NM: per-master response.
REQ-012 s_cyc_o / s_stb_o  out  NS each: per-slave cycle and strobe.
REQ-013 s_we_o  out  1; s_addr_o  out  AW; s_wdata_o  out  DW; s_sel_o  out  SW: request fields, broadcast to all slaves.
REQ-014 s_rdata_i  in  NS*DW; s_ack_i  in  NS: per-slave response.
REQ-015 grant_o  out  NM: one-hot current grant, all zero when idle.

Function
REQ-016 The FSM SHALL have two states: IDLE and OWNED.
REQ-017 IDLE: when any m_cyc_i is high, the next grant is registered at the next edge and the FSM moves to OWNED; the chosen master is the first requester searching upward, with wrap-around, from rr_ptr.
REQ-018 OWNED: the grant is held while the granted m_cyc_i stays high; requests from other masters are ignored.
REQ-019 OWNED -> IDLE at the first edge where the granted m_cyc_i is low; rr_ptr is then set to (granted index + 1) mod NM.
REQ-020 Arbitration latency: exactly 1 cycle from m_cyc_i rising to s_cyc_o/s_stb_o asserting; a back-to-back handover between masters costs 1 IDLE cycle.
REQ-021 Decode is combinational on the granted master's address: slave k is hit when (addr & MASK_k) == BASE_k; on multiple hits the lowest k wins.
REQ-022 In OWNED, s_cyc_o[k] = granted cyc AND hit_k, and s_stb_o[k] = granted stb AND hit_k; the shared request fields mux the granted master's fields and are zero in IDLE.
REQ-023 The hit slave's s_ack_i and s_rdata_i SHALL pass combinationally to the granted master's m_ack_o and m_rdata_o, with zero added latency.
REQ-024 Non-granted masters SHALL see m_ack_o = 0, m_err_o = 0 and m_rdata_o = 0.
REQ-025 Unmapped address: no s_cyc_o/s_stb_o is asserted, and a registered m_err_o pulse is raised one cycle after stb is seen.
REQ-026 Timeout: a 16-bit counter increments each cycle the granted stb is high to a mapped slave without ack, and clears on ack, on stb low, or on err.
REQ-027 When the timeout counter reaches TIMEOUT, a registered m_err_o pulse is raised to the granted master and s_stb_o is forced low for that cycle.
REQ-028 m_err_o SHALL be exactly 1 cycle wide and cannot re-fire in the cycle immediately after a pulse, even though stb is still sampled high then.
REQ-029 m_ack_o and m_err_o are never high together; if s_ack_i arrives in the same cycle the timeout expires, ack wins and no err is raised.
REQ-030 If the granted master drops cyc mid-transfer, slave cyc/stb fall immediately (combinationally), pending err is cancelled and the FSM returns to IDLE at the next edge.

Reset
REQ-031 While rst = 0 at an edge: FSM = IDLE, rr_ptr = 0, timeout counter = 0, err register = 0.
REQ-032 After reset, grant_o, m_ack_o, m_err_o, m_rdata_o, s_cyc_o, s_stb_o and all shared request fields are 0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer without any ack or err being issued.

Verification
REQ-034 Single read: master 0 reads 0x0200_0004, slave 0 acks 2 cycles later with 0xDEAD_BEEF -> s_cyc_o = 0001 one cycle after request; m_rdata_o[0] = 0xDEAD_BEEF with m_ack_o[0] in the same cycle as s_ack_i[0].
REQ-035 Round robin: all 3 masters hold cyc and do 1-beat cycles repeatedly -> grant sequence 0,1,2,0,1,2 with 1 IDLE cycle between grants.
REQ-036 Unmapped: master 1 accesses 0x3000_0000 -> no s_cyc_o asserted; m_err_o[1] is a single 1-cycle pulse one cycle after stb.
REQ-037 Timeout: TIMEOUT = 4, slave 2 never acks -> m_err_o goes high in the cycle after 4 stall cycles, exactly once.
REQ-038 Ack versus timeout collision, and an overlap address 0x1000_1000 hitting slaves 2 and 3 under modified masks -> ack only with no err; lowest slave index selected.
REQ-039 Reset asserted while OWNED with a stalled slave -> all outputs are 0 the next cycle, and the next grant goes to master 0.

Source files
------------

// File: rtl/wb_rr_interconnect.sv
// Shared-bus Wishbone interconnect: round-robin arbitration among NM masters, address decode
// to NS slaves, and an error response for unmapped addresses and stalled slaves.
module wb_rr_interconnect #(
  parameter int unsigned     NM       = 3,
  parameter int unsigned     NS       = 4,
  parameter int unsigned     AW       = 32,
  parameter int unsigned     DW       = 32,
  parameter int unsigned     SW       = DW / 8,
  parameter logic [NS*AW-1:0] SLV_BASE = {32'h1000_1000, 32'h1000_0000,
                                          32'h0C00_0000, 32'h0200_0000},
  parameter logic [NS*AW-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000,
                                          32'hFF00_0000, 32'hFF00_0000},
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_addr_i,
  input  logic [NM*DW-1:0] m_wdata_i,
  input  logic [NM*SW-1:0] m_sel_i,
  output logic [NM*DW-1:0] m_rdata_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NS-1:0]    s_cyc_o,
  output logic [NS-1:0]    s_stb_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_addr_o,
  output logic [DW-1:0]    s_wdata_o,
  output logic [SW-1:0]    s_sel_o,
  input  logic [NS*DW-1:0] s_rdata_i,
  input  logic [NS-1:0]    s_ack_i,
  output logic [NM-1:0]    grant_o
);

  localparam int unsigned MW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned KW = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StOwned = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [MW-1:0] rr_ptr_q, rr_ptr_d;
  logic [MW-1:0] gidx_q, gidx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          req_found;
  logic [MW-1:0] pick_idx;
  logic          owned;
  logic          g_cyc, g_stb;
  logic [AW-1:0] g_addr;
  logic          mapped;
  logic [KW-1:0] slv_idx;
  logic          ack_raw, ack_ok, stall, to_fire, um_fire;
  logic [16:0]   cnt_inc;
  logic [DW-1:0] rdata_sel;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    req_found = 1'b0;
    pick_idx  = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (!req_found && m_cyc_i[(32'(rr_ptr_q) + i) % NM]) begin
        req_found = 1'b1;
        pick_idx  = MW'((32'(rr_ptr_q) + i) % NM);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == StIdle) begin
      if (req_found) begin
        state_d = StOwned;
        gidx_d  = pick_idx;
      end
    end else if (!m_cyc_i[gidx_q]) begin
      state_d  = StIdle;
      rr_ptr_d = (gidx_q == MW'(NM - 1)) ? '0 : gidx_q + 1'b1;
    end
  end

  // Outputs are gated by rst so a transfer caught by reset never completes.
  assign owned  = (state_q == StOwned) && rst;
  assign g_cyc  = owned && m_cyc_i[gidx_q];
  assign g_stb  = g_cyc && m_stb_i[gidx_q];
  assign g_addr = owned ? m_addr_i[gidx_q*AW +: AW] : '0;

  always_comb begin
    grant_o = '0;
    if (owned) grant_o[gidx_q] = 1'b1;
  end

  // Lowest-index slave wins on overlapping windows.
  always_comb begin
    mapped  = 1'b0;
    slv_idx = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (!mapped && ((g_addr & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW])) begin
        mapped  = 1'b1;
        slv_idx = KW'(k);
      end
    end
  end

  assign ack_raw   = s_ack_i[slv_idx];
  assign rdata_sel = s_rdata_i[slv_idx*DW +: DW];
  assign ack_ok    = g_stb && mapped && ack_raw && !err_q;
  assign stall     = g_stb && mapped && !ack_raw && !err_q;
  assign cnt_inc   = {1'b0, cnt_q} + 17'd1;
  assign to_fire   = stall && (cnt_inc == 17'(TIMEOUT));
  assign um_fire   = g_stb && !mapped && !err_q;
  assign err_d     = to_fire || um_fire;
  assign cnt_d     = (stall && !to_fire) ? cnt_inc[15:0] : '0;

  // Strobe is withheld while the error pulse is out so the stalled slave sees the abort.
  always_comb begin
    for (int unsigned k = 0; k < NS; k++) begin
      s_cyc_o[k] = g_cyc && mapped && (slv_idx == KW'(k));
      s_stb_o[k] = g_stb && mapped && (slv_idx == KW'(k)) && !err_q;
    end
  end

  assign s_we_o    = owned && m_we_i[gidx_q];
  assign s_addr_o  = g_addr;
  assign s_wdata_o = owned ? m_wdata_i[gidx_q*DW +: DW] : '0;
  assign s_sel_o   = owned ? m_sel_i[gidx_q*SW +: SW] : '0;

  always_comb begin
    m_rdata_o = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    if (owned) begin
      if (g_cyc && mapped) m_rdata_o[gidx_q*DW +: DW] = rdata_sel;
      m_ack_o[gidx_q] = ack_ok;
      m_err_o[gidx_q] = err_q && g_cyc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Directed bench for wb_rr_interconnect: expected master responses are queued by the stimulus
// and retired by a monitor whenever the DUT raises ack or err.
module tb_wb_rr_interconnect;

  localparam int NM = 3;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NM-1:0]    m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
  logic [NM*AW-1:0] m_addr_i = '0;
  logic [NM*DW-1:0] m_wdata_i = '0;
  logic [NM*SW-1:0] m_sel_i = '0;
  logic [NM*DW-1:0] m_rdata_o;
  logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o, s_ack_i;
  logic             s_we_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_wdata_o;
  logic [SW-1:0]    s_sel_o;
  logic [NS*DW-1:0] s_rdata_i;

  logic [31:0]   slv_data [NS];
  logic [NS-1:0] auto_ack = '0, man_ack = '0;

  assign s_ack_i   = (auto_ack & s_stb_o) | man_ack;
  assign s_rdata_i = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

  always #5 clk = ~clk;

  // Slave 2 window widened so 0x1000_1000 also hits slave 2.
  wb_rr_interconnect #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW), .SW(SW),
    .SLV_BASE({32'h1000_1000, 32'h1000_0000, 32'h0C00_0000, 32'h0200_0000}),
    .SLV_MASK({32'hFFFF_F000, 32'hFFFF_0000, 32'hFF00_0000, 32'hFF00_0000}),
    .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_sel_i(m_sel_i),
    .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] data;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int m, input bit err, input logic [31:0] data);
    resp_t r;
    r.m = m;
    r.err = err;
    r.data = data;
    exp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input bit cyc, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd);
    m_cyc_i[m] = cyc;
    m_stb_i[m] = cyc;
    m_we_i[m]  = we;
    m_addr_i[m*AW +: AW]  = cyc ? addr : 32'h0;
    m_wdata_i[m*DW +: DW] = cyc ? wd : 32'h0;
    m_sel_i[m*SW +: SW]   = cyc ? 4'hF : 4'h0;
  endtask

  task automatic wait_resp(input int m);
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = m_ack_o[m] | m_err_o[m];
    end
    check($sformatf("resp_arrived_m%0d", m), got, 1'b1);
  endtask

  task automatic do_beat(input int m, input logic [31:0] addr);
    set_req(m, 1'b1, 1'b0, addr, 32'h0);
    wait_resp(m);
    tick();
    set_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if ((m_ack_o | m_err_o) != '0) begin
        check("ack_err_exclusive", m_ack_o & m_err_o, 0);
        for (int m = 0; m < NM; m++) begin
          if (m_ack_o[m] || m_err_o[m]) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_resp: master %0d ack=%b err=%b, none expected",
                       m, m_ack_o[m], m_err_o[m]);
            end else begin
              e = exp_q.pop_front();
              check("resp_master", m, e.m);
              check("resp_is_err", m_err_o[m], e.err);
              if (!e.err) check("resp_rdata", m_rdata_o[m*DW +: DW], e.data);
            end
          end
        end
      end
    end
  end

  // Grant sequence recorder
  bit            gw_en = 1'b0;
  int            gq_idx[$];
  int            gq_gap[$];
  int            idle_run = 0;
  logic [NM-1:0] prev_g = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (gw_en) begin
        if (grant_o == '0) begin
          idle_run++;
        end else begin
          if (prev_g == '0) begin
            check("grant_onehot", $countones(grant_o), 1);
            for (int i = NM - 1; i >= 0; i--) if (grant_o[i]) gq_idx.push_back(i);
            gq_gap.push_back(idle_run);
          end
          idle_run = 0;
        end
        prev_g = grant_o;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    slv_data[0] = 32'hDEAD_BEEF;
    slv_data[1] = 32'h1111_1111;
    slv_data[2] = 32'h2222_2222;
    slv_data[3] = 32'h3333_3333;

    // Reset
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_grant", grant_o, 0);
    check("rst_m_ack", m_ack_o, 0);
    check("rst_m_err", m_err_o, 0);
    check("rst_m_rdata", m_rdata_o, 0);
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_s_stb", s_stb_o, 0);
    check("rst_s_we", s_we_o, 0);
    check("rst_s_addr", s_addr_o, 0);
    check("rst_s_wdata", s_wdata_o, 0);
    check("rst_s_sel", s_sel_o, 0);

    // Single read, slave 0 acks two cycles after the request reaches it
    tick();
    set_req(0, 1'b1, 1'b0, 32'h0200_0004, 32'h0);
    push_exp(0, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("read_no_cyc_same_cycle", s_cyc_o, 0);
    tick();
    @(negedge clk);
    check("read_s_cyc", s_cyc_o, 4'b0001);
    check("read_s_stb", s_stb_o, 4'b0001);
    check("read_grant", grant_o, 3'b001);
    check("read_s_addr", s_addr_o, 32'h0200_0004);
    check("read_no_early_ack", m_ack_o, 0);
    tick();
    tick();
    man_ack[0] = 1'b1;
    @(negedge clk);
    check("read_ack_same_cycle", m_ack_o, 3'b001);
    check("read_rdata_bus", m_rdata_o, {64'h0, 32'hDEAD_BEEF});
    tick();
    man_ack[0] = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Write from master 2 to slave 1, zero-latency slave
    auto_ack[1] = 1'b1;
    set_req(2, 1'b1, 1'b1, 32'h0C00_0010, 32'hCAFE_F00D);
    push_exp(2, 1'b0, 32'h1111_1111);
    tick();
    @(negedge clk);
    check("write_s_cyc", s_cyc_o, 4'b0010);
    check("write_s_we", s_we_o, 1'b1);
    check("write_s_wdata", s_wdata_o, 32'hCAFE_F00D);
    check("write_s_sel", s_sel_o, 4'hF);
    check("write_grant", grant_o, 3'b100);
    check("write_ack", m_ack_o, 3'b100);
    tick();
    set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Round robin: all three masters contend, two beats each
    for (int r = 0; r < 2; r++) for (int m = 0; m < NM; m++) push_exp(m, 1'b0, 32'h1111_1111);
    gw_en = 1'b1;
    fork
      begin
        for (int r = 0; r < 2; r++) begin do_beat(0, 32'h0C00_0000); tick(); end
      end
      begin
        for (int r = 0; r < 2; r++) begin do_beat(1, 32'h0C00_0004); tick(); end
      end
      begin
        for (int r = 0; r < 2; r++) begin do_beat(2, 32'h0C00_0008); tick(); end
      end
    join
    gw_en = 1'b0;
    check("rr_grant_count", gq_idx.size(), 6);
    for (int i = 0; i < gq_idx.size() && i < 6; i++) begin
      check($sformatf("rr_grant_%0d", i), gq_idx[i], i % 3);
      if (i > 0) check($sformatf("rr_idle_gap_%0d", i), gq_gap[i], 1);
    end
    tick();

    // Unmapped address from master 1
    set_req(1, 1'b1, 1'b0, 32'h3000_0000, 32'h0);
    push_exp(1, 1'b1, 32'h0);
    tick();
    @(negedge clk);
    check("unmapped_no_s_cyc", s_cyc_o, 0);
    check("unmapped_no_s_stb", s_stb_o, 0);
    check("unmapped_grant", grant_o, 3'b010);
    check("unmapped_no_err_yet", m_err_o, 0);
    tick();
    @(negedge clk);
    check("unmapped_err_pulse", m_err_o, 3'b010);
    tick();
    @(negedge clk);
    check("unmapped_err_one_cycle", m_err_o, 0);
    tick();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("unmapped_err_cancel_on_drop", m_err_o, 0);
    tick();

    // Timeout: slave 2 never acks, TIMEOUT = 4
    set_req(2, 1'b1, 1'b0, 32'h1000_0020, 32'h0);
    push_exp(2, 1'b1, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("to_stall%0d_no_err", i), m_err_o, 0);
      check($sformatf("to_stall%0d_stb", i), s_stb_o, 4'b0100);
    end
    tick();
    @(negedge clk);
    check("to_err_pulse", m_err_o, 3'b100);
    check("to_stb_forced_low", s_stb_o, 0);
    check("to_cyc_held", s_cyc_o, 4'b0100);
    tick();
    @(negedge clk);
    check("to_no_refire", m_err_o, 0);
    tick();
    set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Overlapping windows and ack arriving in the expiry cycle
    set_req(0, 1'b1, 1'b0, 32'h1000_1000, 32'h0);
    push_exp(0, 1'b0, 32'h2222_2222);
    tick();
    @(negedge clk);
    check("overlap_lowest_slave", s_cyc_o, 4'b0100);
    tick();
    tick();
    tick();
    man_ack[2] = 1'b1;
    @(negedge clk);
    check("collide_ack", m_ack_o, 3'b001);
    check("collide_no_err_same", m_err_o, 0);
    tick();
    man_ack[2] = 1'b0;
    @(negedge clk);
    check("collide_no_err_after", m_err_o, 0);
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Reset while master 1 owns a stalled slave; round-robin pointer must return to 0
    set_req(1, 1'b1, 1'b0, 32'h1000_0040, 32'h0);
    tick();
    tick();
    @(negedge clk);
    check("rst_mid_grant_before", grant_o, 3'b010);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_grant", grant_o, 0);
    check("rst_mid_s_cyc", s_cyc_o, 0);
    check("rst_mid_s_stb", s_stb_o, 0);
    check("rst_mid_m_ack", m_ack_o, 0);
    check("rst_mid_m_err", m_err_o, 0);
    check("rst_mid_m_rdata", m_rdata_o, 0);
    check("rst_mid_s_addr", s_addr_o, 0);
    check("rst_mid_s_fields", {s_we_o, s_wdata_o, s_sel_o}, 0);
    tick();
    rst = 1'b1;
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    auto_ack[0] = 1'b1;
    push_exp(0, 1'b0, 32'hDEAD_BEEF);
    push_exp(1, 1'b0, 32'hDEAD_BEEF);
    fork
      do_beat(0, 32'h0200_0000);
      do_beat(1, 32'h0200_0008);
    join
    repeat (4) tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
